// File: rtl/axilite_master_queued.sv
// axilite_master_queued: AXI4-Lite master fed by a DEPTH-entry command FIFO.
// Commands issue in order with one transaction outstanding; each completion
// returns a single-cycle registered response pulse.
// Optional watchdog: define AXIL_MASTER_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES non-idle cycles and report it with rsp_timeout.
//
// state    | meaning
// IDLE     | nothing outstanding; pops the FIFO head when one is available
// WR_AW_W  | write address and data offered, each held until its own handshake
// WR_RESP  | bready high, waiting for the write response
// RD_AR    | read address offered until accepted
// RD_RESP  | rready high, waiting for read data
module axilite_master_queued #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 64,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   output logic [ADDR_W-1:0]          m_axi_awaddr,
   output logic [2:0]                 m_axi_awprot,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [DATA_W-1:0]          m_axi_wdata,
   output logic [DATA_W/8-1:0]        m_axi_wstrb,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready,
   output logic [ADDR_W-1:0]          m_axi_araddr,
   output logic [2:0]                 m_axi_arprot,
   output logic                       m_axi_arvalid,
   input  logic                       m_axi_arready,
   input  logic [DATA_W-1:0]          m_axi_rdata,
   input  logic [1:0]                 m_axi_rresp,
   input  logic                       m_axi_rvalid,
   output logic                       m_axi_rready,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_w_r,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [DATA_W-1:0]          cmd_data,
   input  logic [DATA_W/8-1:0]        cmd_strb,
   output logic                       rsp_valid,
   output logic                       rsp_w_r,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [1:0]                 rsp_status,
   output logic                       rsp_timeout,
   output logic [$clog2(DEPTH):0]     queue_level,
   output logic                       busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int SW = DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_AW_W, ST_WR_RESP, ST_RD_AR, ST_RD_RESP
   } state_t;

   state_t              state;
   logic                mem_w_r [DEPTH];
   logic [ADDR_W-1:0]   mem_addr [DEPTH];
   logic [DATA_W-1:0]   mem_data [DEPTH];
   logic [SW-1:0]       mem_strb [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                push, pop, fifo_nempty;
   logic                b_hs, r_hs, aw_done, w_done;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign cmd_ready    = (queue_level != LW'(DEPTH));
   assign fifo_nempty  = (queue_level != '0);
   assign push         = cmd_valid && cmd_ready;
   // bready/rready are high for the whole of their response states
   assign b_hs         = (state == ST_WR_RESP) && m_axi_bvalid;
   assign r_hs         = (state == ST_RD_RESP) && m_axi_rvalid;
   // completion edges also issue the next command (back-to-back)
   assign pop          = fifo_nempty && ((state == ST_IDLE) || b_hs || r_hs);
   assign aw_done      = !m_axi_awvalid || m_axi_awready;
   assign w_done       = !m_axi_wvalid || m_axi_wready;
   assign busy         = (state != ST_IDLE) || fifo_nempty;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          hs_any, abort;

   assign hs_any = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready) ||
                   (m_axi_arvalid && m_axi_arready) || b_hs || r_hs;
   // a handshake on the terminal cycle takes precedence over the abort
   assign abort  = (state != ST_IDLE) && (tmo_cnt == '0) && !hs_any;

   // watchdog down-counter, reloaded whenever a command issues
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         tmo_cnt <= '0;
      else if (pop)
         tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if ((state != ST_IDLE) && (tmo_cnt != '0))
         tmo_cnt <= tmo_cnt - 1'b1;
   end
`else
   // no watchdog: the limit parameter has no effect
   assign rsp_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   // command storage; entries are only read after being written
   always_ff @(posedge aclk) begin
      if (push) begin
         mem_w_r[wr_ptr]  <= cmd_w_r;
         mem_addr[wr_ptr] <= cmd_addr;
         mem_data[wr_ptr] <= cmd_data;
         mem_strb[wr_ptr] <= cmd_strb;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            queue_level <= queue_level + 1'b1;
         else if (!push && pop)
            queue_level <= queue_level - 1'b1;
      end
   end

   // transaction FSM with registered AXI and response outputs
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_IDLE;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_w_r       <= 1'b0;
         rsp_data      <= '0;
         rsp_status    <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
         rsp_timeout   <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_WR_AW_W: begin
               if (m_axi_awvalid && m_axi_awready) begin
                  m_axi_awvalid <= 1'b0;
                  m_axi_awaddr  <= '0;
               end
               if (m_axi_wvalid && m_axi_wready) begin
                  m_axi_wvalid <= 1'b0;
                  m_axi_wdata  <= '0;
                  m_axi_wstrb  <= '0;
               end
               if (aw_done && w_done) begin
                  state        <= ST_WR_RESP;
                  m_axi_bready <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (m_axi_bvalid) begin
                  state        <= ST_IDLE;
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_w_r      <= 1'b0;
                  rsp_data     <= '0;
                  rsp_status   <= m_axi_bresp;
`ifdef AXIL_MASTER_TIMEOUT_EN
                  rsp_timeout  <= 1'b0;
`endif
               end
            end
            ST_RD_AR: begin
               if (m_axi_arready) begin
                  state         <= ST_RD_RESP;
                  m_axi_arvalid <= 1'b0;
                  m_axi_araddr  <= '0;
                  m_axi_rready  <= 1'b1;
               end
            end
            ST_RD_RESP: begin
               if (m_axi_rvalid) begin
                  state        <= ST_IDLE;
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_w_r      <= 1'b1;
                  rsp_data     <= m_axi_rdata;
                  rsp_status   <= m_axi_rresp;
`ifdef AXIL_MASTER_TIMEOUT_EN
                  rsp_timeout  <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
         if (abort) begin
            state         <= ST_IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_w_r       <= (state == ST_RD_AR) || (state == ST_RD_RESP);
            rsp_data      <= '0;
            rsp_status    <= 2'b10;
            rsp_timeout   <= 1'b1;
         end
`endif
         if (pop) begin
            if (mem_w_r[rd_ptr]) begin
               state         <= ST_RD_AR;
               m_axi_arvalid <= 1'b1;
               m_axi_araddr  <= mem_addr[rd_ptr];
            end else begin
               state         <= ST_WR_AW_W;
               m_axi_awvalid <= 1'b1;
               m_axi_awaddr  <= mem_addr[rd_ptr];
               m_axi_wvalid  <= 1'b1;
               m_axi_wdata   <= mem_data[rd_ptr];
               m_axi_wstrb   <= mem_strb[rd_ptr];
            end
         end
      end
   end

endmodule

// File: tb/tb_axilite_master_queued.sv
// Directed bench for axilite_master_queued: single/skewed writes, read,
// queue fill with back-to-back drain, mid-transaction reset and, when
// AXIL_MASTER_TIMEOUT_EN is defined, the watchdog abort.
module tb_axilite_master_queued;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = 8;
   localparam int DEPTH = 4;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]    m_axi_awprot, m_axi_arprot;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [SW-1:0] m_axi_wstrb;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;
   logic          cmd_valid, cmd_ready, cmd_w_r;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid, rsp_w_r, rsp_timeout, busy;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_status;
   logic [2:0]    queue_level;

   axilite_master_queued #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_w_r(cmd_w_r),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_w_r(rsp_w_r), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
      .queue_level(queue_level), .busy(busy)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge aclk);
   endtask

   task automatic drive_cmd(input logic w_r, input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] s);
      cmd_valid = 1'b1;
      cmd_w_r   = w_r;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_strb  = s;
   endtask

   // response and issue recorder, sampled at the active edge
   int          cyc_cnt = 0;
   logic        rq_w_r[$];
   logic [63:0] rq_data[$];
   logic [1:0]  rq_status[$];
   int          rq_cyc[$];
   logic [31:0] iss_addr[$];
   always @(posedge aclk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (rsp_valid) begin
         rq_w_r.push_back(rsp_w_r);
         rq_data.push_back(rsp_data);
         rq_status.push_back(rsp_status);
         rq_cyc.push_back(cyc_cnt);
      end
      if (m_axi_awvalid && m_axi_awready) iss_addr.push_back(m_axi_awaddr);
      if (m_axi_arvalid && m_axi_arready) iss_addr.push_back(m_axi_araddr);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int base;
      int nsz;
      aresetn = 1'b0;
      cmd_valid = 1'b0; cmd_w_r = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      cyc(2);
      chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
      chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
      chk("rst_bready", 64'(m_axi_bready), 64'd0);
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_rready", 64'(m_axi_rready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_level", 64'(queue_level), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      aresetn = 1'b1;
      cyc(1);

      // single write, aw and w accepted together, OKAY two cycles later
      drive_cmd(1'b0, 32'h10, 64'hA5A5, 8'hFF);
      cyc(1);
      cmd_valid = 1'b0;
      chk("wr1_level", 64'(queue_level), 64'd1);
      chk("wr1_aw_not_yet", 64'(m_axi_awvalid), 64'd0);
      cyc(1);
      chk("wr1_awvalid", 64'(m_axi_awvalid), 64'd1);
      chk("wr1_awaddr", 64'(m_axi_awaddr), 64'h10);
      chk("wr1_wvalid", 64'(m_axi_wvalid), 64'd1);
      chk("wr1_wdata", m_axi_wdata, 64'hA5A5);
      chk("wr1_wstrb", 64'(m_axi_wstrb), 64'hFF);
      chk("wr1_prot", 64'(m_axi_awprot), 64'd0);
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      cyc(1);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      chk("wr1_aw_drop", 64'(m_axi_awvalid), 64'd0);
      chk("wr1_awaddr_zero", 64'(m_axi_awaddr), 64'd0);
      chk("wr1_w_drop", 64'(m_axi_wvalid), 64'd0);
      chk("wr1_bready", 64'(m_axi_bready), 64'd1);
      cyc(1);
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      cyc(1);
      m_axi_bvalid = 1'b0;
      chk("wr1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("wr1_rsp_w_r", 64'(rsp_w_r), 64'd0);
      chk("wr1_rsp_status", 64'(rsp_status), 64'd0);
      chk("wr1_rsp_data", rsp_data, 64'd0);
      chk("wr1_rsp_timeout", 64'(rsp_timeout), 64'd0);
      chk("wr1_bready_drop", 64'(m_axi_bready), 64'd0);
      cyc(1);
      chk("wr1_rsp_pulse", 64'(rsp_valid), 64'd0);
      chk("wr1_busy", 64'(busy), 64'd0);
      chk("wr1_rsp_count", 64'(rq_w_r.size()), 64'd1);

      // skewed write: wready three cycles before awready, SLVERR response
      drive_cmd(1'b0, 32'h30, 64'h1234, 8'h0F);
      cyc(1);
      cmd_valid = 1'b0;
      cyc(1);
      chk("wr2_awvalid", 64'(m_axi_awvalid), 64'd1);
      chk("wr2_wvalid", 64'(m_axi_wvalid), 64'd1);
      m_axi_wready = 1'b1;
      cyc(1);
      m_axi_wready = 1'b0;
      chk("wr2_w_drop", 64'(m_axi_wvalid), 64'd0);
      chk("wr2_wdata_zero", m_axi_wdata, 64'd0);
      chk("wr2_aw_hold", 64'(m_axi_awvalid), 64'd1);
      chk("wr2_awaddr_hold", 64'(m_axi_awaddr), 64'h30);
      cyc(2);
      chk("wr2_aw_hold2", 64'(m_axi_awvalid), 64'd1);
      chk("wr2_no_bready", 64'(m_axi_bready), 64'd0);
      m_axi_awready = 1'b1;
      cyc(1);
      m_axi_awready = 1'b0;
      chk("wr2_aw_drop", 64'(m_axi_awvalid), 64'd0);
      chk("wr2_bready", 64'(m_axi_bready), 64'd1);
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
      cyc(1);
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      chk("wr2_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("wr2_rsp_status", 64'(rsp_status), 64'd2);
      chk("wr2_rsp_w_r", 64'(rsp_w_r), 64'd0);
      cyc(1);
      chk("wr2_rsp_pulse", 64'(rsp_valid), 64'd0);
      chk("wr2_rsp_count", 64'(rq_w_r.size()), 64'd2);

      // read with rvalid four cycles after arready
      drive_cmd(1'b1, 32'h20, 64'd0, 8'd0);
      cyc(1);
      cmd_valid = 1'b0;
      cyc(1);
      chk("rd_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("rd_araddr", 64'(m_axi_araddr), 64'h20);
      chk("rd_no_aw", 64'(m_axi_awvalid), 64'd0);
      m_axi_arready = 1'b1;
      cyc(1);
      m_axi_arready = 1'b0;
      chk("rd_ar_drop", 64'(m_axi_arvalid), 64'd0);
      chk("rd_araddr_zero", 64'(m_axi_araddr), 64'd0);
      chk("rd_rready", 64'(m_axi_rready), 64'd1);
      cyc(3);
      m_axi_rvalid = 1'b1; m_axi_rdata = 64'hDEADBEEF; m_axi_rresp = 2'b00;
      cyc(1);
      m_axi_rvalid = 1'b0;
      chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rd_rsp_data", rsp_data, 64'hDEADBEEF);
      chk("rd_rsp_w_r", 64'(rsp_w_r), 64'd1);
      chk("rd_rsp_status", 64'(rsp_status), 64'd0);
      chk("rd_rready_drop", 64'(m_axi_rready), 64'd0);
      cyc(1);
      chk("rd_rsp_pulse", 64'(rsp_valid), 64'd0);

      // queue: five commands with the slave stalled, then drain
      iss_addr.delete();
      base = rq_w_r.size();
      for (int i = 0; i < 5; i++) begin
         drive_cmd(i[0], 32'h100 + 32'(4 * i), 64'h1000 + 64'(i), 8'hFF);
         cyc(1);
         if (i == 1) begin
            chk("q_level_push_pop", 64'(queue_level), 64'd1);
            chk("q_first_issued", 64'(m_axi_awvalid), 64'd1);
         end
      end
      drive_cmd(1'b0, 32'h200, 64'h77, 8'hFF);
      chk("q_full_level", 64'(queue_level), 64'd4);
      chk("q_full_ready", 64'(cmd_ready), 64'd0);
      chk("q_stall_awaddr", 64'(m_axi_awaddr), 64'h100);
      cyc(2);
      chk("q_ignore_level", 64'(queue_level), 64'd4);
      chk("q_ignore_ready", 64'(cmd_ready), 64'd0);
      cmd_valid = 1'b0;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rresp = 2'b00;
      m_axi_rdata = 64'h55AA33CC;
      for (int k = 0; k < 40 && rq_w_r.size() < base + 5; k++) cyc(1);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      chk("q_rsp_count", 64'(rq_w_r.size()), 64'(base + 5));
      chk("q_issue_count", 64'(iss_addr.size()), 64'd5);
      if (rq_w_r.size() >= base + 5 && iss_addr.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("q_order_addr%0d", i), 64'(iss_addr[i]), 64'h100 + 64'(4 * i));
            chk($sformatf("q_w_r%0d", i), 64'(rq_w_r[base + i]), 64'(i % 2));
            chk($sformatf("q_data%0d", i), rq_data[base + i],
                (i % 2 == 1) ? 64'h55AA33CC : 64'd0);
            chk($sformatf("q_status%0d", i), 64'(rq_status[base + i]), 64'd0);
            if (i > 0)
               chk($sformatf("q_b2b%0d", i), 64'(rq_cyc[base + i] - rq_cyc[base + i - 1]), 64'd2);
         end
      end
      cyc(2);
      chk("q_drained_level", 64'(queue_level), 64'd0);
      chk("q_drained_busy", 64'(busy), 64'd0);
      chk("q_no_extra_rsp", 64'(rq_w_r.size()), 64'(base + 5));

      // reset during WR_RESP with two commands queued
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      drive_cmd(1'b0, 32'h300, 64'h1, 8'h01);
      cyc(1);
      drive_cmd(1'b0, 32'h304, 64'h2, 8'h01);
      cyc(1);
      drive_cmd(1'b1, 32'h308, 64'h3, 8'h01);
      cyc(1);
      cmd_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      chk("rst2_pre_bready", 64'(m_axi_bready), 64'd1);
      chk("rst2_pre_level", 64'(queue_level), 64'd2);
      nsz = rq_w_r.size();
      #2 aresetn = 1'b0;
      #1;
      chk("rst2_bready", 64'(m_axi_bready), 64'd0);
      chk("rst2_awvalid", 64'(m_axi_awvalid), 64'd0);
      chk("rst2_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst2_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst2_level", 64'(queue_level), 64'd0);
      chk("rst2_busy", 64'(busy), 64'd0);
      chk("rst2_cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge aclk);
      aresetn = 1'b1;
      cyc(6);
      chk("rst2_no_rsp", 64'(rq_w_r.size()), 64'(nsz));
      chk("rst2_level_after", 64'(queue_level), 64'd0);
      chk("rst2_idle_aw", 64'(m_axi_awvalid), 64'd0);
      chk("rst2_idle_ar", 64'(m_axi_arvalid), 64'd0);

`ifdef AXIL_MASTER_TIMEOUT_EN
      // watchdog: arready never arrives
      drive_cmd(1'b1, 32'h40, 64'd0, 8'd0);
      cyc(1);
      cmd_valid = 1'b0;
      cyc(1);
      chk("tmo_arvalid", 64'(m_axi_arvalid), 64'd1);
      cyc(15);
      chk("tmo_still_waiting", 64'(m_axi_arvalid), 64'd1);
      chk("tmo_no_rsp_yet", 64'(rsp_valid), 64'd0);
      cyc(1);
      chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("tmo_flag", 64'(rsp_timeout), 64'd1);
      chk("tmo_status", 64'(rsp_status), 64'd2);
      chk("tmo_data", rsp_data, 64'd0);
      chk("tmo_w_r", 64'(rsp_w_r), 64'd1);
      chk("tmo_ar_drop", 64'(m_axi_arvalid), 64'd0);
      drive_cmd(1'b1, 32'h44, 64'd0, 8'd0);
      cyc(1);
      cmd_valid = 1'b0;
      cyc(1);
      chk("tmo_next_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("tmo_next_araddr", 64'(m_axi_araddr), 64'h44);
      m_axi_arready = 1'b1;
      cyc(1);
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b1; m_axi_rdata = 64'h99;
      cyc(1);
      m_axi_rvalid = 1'b0;
      chk("tmo_next_rsp", 64'(rsp_valid), 64'd1);
      chk("tmo_next_flag", 64'(rsp_timeout), 64'd0);
      chk("tmo_next_data", rsp_data, 64'h99);
`endif

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
